// File: rtl/gcd_datapath_if.sv
// rtl/gcd_datapath_if.sv - controller/datapath strobe and status bundle for the GCD unit
interface gcd_datapath_if #(
   parameter int WIDTH = 8,
   parameter int CW    = 8
);
   logic [WIDTH-1:0] data_in;
   logic             loada;
   logic             loadb;
   logic             loadp;
   logic             clearp;
   logic             sel1;
   logic             sel2;
   logic             selb;
   logic             done;
   logic             eq;
   logic             lt;
   logic             gt;
   logic [WIDTH-1:0] gcd_out;
   logic [CW-1:0]    iter_count;
   logic             result_valid;
   logic             zero_err;

   modport master (
      output data_in, loada, loadb, loadp, clearp, sel1, sel2, selb, done,
      input  eq, lt, gt, gcd_out, iter_count, result_valid, zero_err
   );

   modport slave (
      input  data_in, loada, loadb, loadp, clearp, sel1, sel2, selb, done,
      output eq, lt, gt, gcd_out, iter_count, result_valid, zero_err
   );
endinterface

// File: rtl/gcd_datapath.sv
// rtl/gcd_datapath.sv - GCD operand registers, subtractor, step counter, comparator and result capture
module gcd_datapath #(
   parameter int WIDTH = 8,
   parameter int CW    = 8
) (
   input  logic         clock,
   input  logic         resetn,
   gcd_datapath_if.slave bus
);
   localparam logic [CW-1:0] P_MAX = '1;
   localparam logic [CW-1:0] P_ONE = {{(CW-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [CW-1:0]    p;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] subtrahend;
   logic [WIDTH-1:0] gcd_q;
   logic             done_q;
   logic             valid_q;
   logic             zero_q;
   logic             capture;

   // sel2 is deliberately unused: sel1=0 always means B-A
   always_comb begin
      diff       = bus.sel1 ? (a - b) : (b - a);
      subtrahend = bus.sel1 ? b : a;
      capture    = bus.done & ~done_q;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         a       <= '0;
         b       <= '0;
         p       <= '0;
         gcd_q   <= '0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         if (bus.loada)
            a <= bus.sel1 ? diff : bus.data_in;
         if (bus.loadb)
            b <= bus.selb ? bus.data_in : diff;

         if (bus.clearp)
            p <= '0;
         else if (bus.loadp && (p != P_MAX))
            p <= p + P_ONE;

         if (bus.clearp)
            zero_q <= 1'b0;
         else if (bus.loadp && (subtrahend == '0))
            zero_q <= 1'b1;

         done_q  <= bus.done;
         valid_q <= capture;
         if (capture)
            gcd_q <= a;
      end
   end

   assign bus.eq           = (a == b);
   assign bus.lt           = (a < b);
   assign bus.gt           = (a > b);
   assign bus.gcd_out      = gcd_q;
   assign bus.iter_count   = p;
   assign bus.result_valid = valid_q;
   assign bus.zero_err     = zero_q;
endmodule

// File: tb/tb_gcd_datapath.sv
// tb/tb_gcd_datapath.sv - bench driving the GCD datapath as its controller, against a Euclid reference
module tb_gcd_datapath;
   logic       clock = 1'b0;
   logic       resetn;
   logic [7:0] data_in;
   logic       loada, loadb, loadp, clearp, sel1, sel2, selb, done;
   int         errors = 0;
   int         checks = 0;
   int         ma, mb;

   always #5 clock = ~clock;

   gcd_datapath_if #(.WIDTH(8), .CW(8)) if8 ();
   gcd_datapath_if #(.WIDTH(8), .CW(4)) if4 ();

   assign if8.data_in = data_in;  assign if4.data_in = data_in;
   assign if8.loada   = loada;    assign if4.loada   = loada;
   assign if8.loadb   = loadb;    assign if4.loadb   = loadb;
   assign if8.loadp   = loadp;    assign if4.loadp   = loadp;
   assign if8.clearp  = clearp;   assign if4.clearp  = clearp;
   assign if8.sel1    = sel1;     assign if4.sel1    = sel1;
   assign if8.sel2    = sel2;     assign if4.sel2    = sel2;
   assign if8.selb    = selb;     assign if4.selb    = selb;
   assign if8.done    = done;     assign if4.done    = done;

   gcd_datapath #(.WIDTH(8), .CW(8)) dut8 (.clock(clock), .resetn(resetn), .bus(if8.slave));
   gcd_datapath #(.WIDTH(8), .CW(4)) dut4 (.clock(clock), .resetn(resetn), .bus(if4.slave));

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Euclid by division: subtract steps = sum of quotients minus the final equalising one
   task automatic ref_gcd(input int x, input int y, output int g, output int steps);
      int u, v, t, s;
      u = x; v = y; s = 0;
      while (v != 0) begin
         s += u / v;
         t = u % v;
         u = v;
         v = t;
      end
      g = u;
      steps = s - 1;
   endtask

   function automatic int sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      loada = 0; loadb = 0; loadp = 0; clearp = 0;
      sel1 = 0; sel2 = 0; selb = 0; done = 0; data_in = '0;
   endtask

   task automatic check_cmp(input string tag);
      chk({tag, "_eq"}, int'(if8.eq), int'(ma == mb));
      chk({tag, "_lt"}, int'(if8.lt), int'(ma < mb));
      chk({tag, "_gt"}, int'(if8.gt), int'(ma > mb));
   endtask

   task automatic load_ops(input int x, input int y);
      idle();
      loada = 1; data_in = x[7:0]; clearp = 1;
      tick();
      idle();
      loadb = 1; selb = 1; data_in = y[7:0];
      sel2 = 1'($urandom);
      tick();
      idle();
      ma = x; mb = y;
   endtask

   task automatic sub_step();
      idle();
      loadp = 1;
      sel2  = 1'($urandom);
      data_in = 8'($urandom);
      if (ma > mb) begin
         loada = 1; sel1 = 1;
         ma = ma - mb;
      end else begin
         loadb = 1; sel1 = 0; selb = 0;
         mb = mb - ma;
      end
      tick();
      idle();
   endtask

   task automatic run(input int x, input int y, input string tag);
      int g, steps, n;
      ref_gcd(x, y, g, steps);
      load_ops(x, y);
      check_cmp({tag, "_load"});
      n = 0;
      while (!if8.eq && n < 600) begin
         sub_step();
         n++;
         if (n <= 3) check_cmp({tag, "_step"});
      end
      chk({tag, "_timeout"}, int'(n < 600), 1);
      check_cmp({tag, "_final"});
      chk({tag, "_iter8"}, int'(if8.iter_count), sat(steps, 255));
      chk({tag, "_iter4"}, int'(if4.iter_count), sat(steps, 15));
      chk({tag, "_zerr"}, int'(if8.zero_err), 0);
      done = 1;
      tick();
      chk({tag, "_valid"}, int'(if8.result_valid), 1);
      chk({tag, "_gcd8"}, int'(if8.gcd_out), g);
      chk({tag, "_gcd4"}, int'(if4.gcd_out), g);
      done = 0;
      tick();
      chk({tag, "_valid_drop"}, int'(if8.result_valid), 0);
      chk({tag, "_gcd_hold"}, int'(if8.gcd_out), g);
   endtask

   initial begin
      int pulses, x, y;
      idle();
      resetn = 0;
      #12;
      ma = 0; mb = 0;
      chk("rst_gcd", int'(if8.gcd_out), 0);
      chk("rst_iter", int'(if8.iter_count), 0);
      chk("rst_valid", int'(if8.result_valid), 0);
      chk("rst_zerr", int'(if8.zero_err), 0);
      check_cmp("rst");
      @(negedge clock);
      resetn = 1;
      tick();

      run(36, 24, "r36_24");
      run(7, 7, "r7_7");
      run(1, 255, "r1_255");
      run(24, 36, "r24_36");
      for (int i = 0; i < 8; i++) begin
         x = int'($urandom_range(1, 255));
         y = int'($urandom_range(1, 255));
         run(x, y, "rand");
      end

      // Zero operand: lt never resolves and the step flags the lockup
      load_ops(0, 5);
      sub_step();
      chk("zero_lt", int'(if8.lt), 1);
      chk("zero_b", int'(if8.gt), 0);
      chk("zero_err_set", int'(if8.zero_err), 1);
      chk("zero_iter", int'(if8.iter_count), 1);
      sub_step();
      chk("zero_err_sticky", int'(if8.zero_err), 1);
      clearp = 1; loadp = 1; sel1 = 0;
      tick();
      idle();
      chk("zero_clr_iter", int'(if8.iter_count), 0);
      chk("zero_clr_err", int'(if8.zero_err), 0);

      // Asynchronous reset mid-run
      load_ops(1, 255);
      for (int i = 0; i < 3; i++) sub_step();
      chk("pre_rst_iter", int'(if8.iter_count), 3);
      @(posedge clock);
      #2;
      resetn = 0;
      #1;
      ma = 0; mb = 0;
      chk("arst_iter", int'(if8.iter_count), 0);
      chk("arst_gcd", int'(if8.gcd_out), 0);
      chk("arst_valid", int'(if8.result_valid), 0);
      check_cmp("arst");
      @(negedge clock);
      resetn = 1;
      tick();
      run(36, 24, "post_rst");

      // done held high: a single capture pulse
      load_ops(9, 9);
      done = 1;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         done = 1;
         if (if8.result_valid) pulses++;
      end
      done = 0;
      tick();
      if (if8.result_valid) pulses++;
      chk("hold_pulses", pulses, 1);
      chk("hold_gcd", int'(if8.gcd_out), 9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
